serial_dft_bins: RTL

Multi-bin streaming DFT engine: accumulates `NUM_BINS` complex DFT bins over a frame of `FRAME_LENGTH` real samples, one sample per accepted `valid_i`, using a complex multiply-accumulate per bin with caller-supplied twiddles. Completed frames are latched into a one-frame result buffer and drained one bin per cycle over a valid/ready stream. It generalises the single-bin serial DFT node in `fft/` with multiple bins, frame resync, output scaling/narrowing, backpressure and overrun reporting.

---
 rtl/dft_pkg.sv | 35 +++
 rtl/dft_cmac.sv | 48 ++++
 rtl/serial_dft_bins.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dft_pkg.sv
// Shared definitions for the multi-bin serial DFT engine.
// Optional feature: SERIAL_DFT_SAT_EN selects saturating output narrowing;
// when undefined, narrowing wraps (MSBs dropped).
package dft_pkg;

   localparam int unsigned DFT_W_WIDTH = 16;
   localparam int unsigned DFT_X_WIDTH = 16;
   localparam int unsigned DFT_S_WIDTH = 40;
   localparam int unsigned DFT_O_WIDTH = 32;

   typedef enum logic {
      IDLE,
      DRAIN
   } dft_state_t;

   // Narrow a sign-extended 64-bit value to ow bits; the result is returned
   // sign-extended so the caller simply keeps the low ow bits.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                     input int unsigned ow);
`ifdef SERIAL_DFT_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
`else
      logic signed [63:0] t;
      t = v <<< (64 - ow);
      return t >>> (64 - ow);
`endif
   endfunction

endpackage

// File: rtl/dft_cmac.sv
// One complex multiply-accumulate lane: re/im accumulators that restart from
// the current product on the first sample of a frame. sum_* is the value the
// accumulators take at the next accepted sample (used to capture final sums).
module dft_cmac import dft_pkg::*; #(
   parameter int unsigned W_WIDTH = DFT_W_WIDTH,
   parameter int unsigned X_WIDTH = DFT_X_WIDTH,
   parameter int unsigned S_WIDTH = DFT_S_WIDTH
) (
   input  logic                      clk,
   input  logic                      arstn,
   input  logic                      en,
   input  logic                      first,
   input  logic signed [X_WIDTH-1:0] x,
   input  logic signed [W_WIDTH-1:0] w_re,
   input  logic signed [W_WIDTH-1:0] w_im,
   output logic signed [S_WIDTH-1:0] sum_re,
   output logic signed [S_WIDTH-1:0] sum_im
);

   logic signed [W_WIDTH+X_WIDTH-1:0] prod_re;
   logic signed [W_WIDTH+X_WIDTH-1:0] prod_im;
   logic signed [S_WIDTH-1:0]         ext_re;
   logic signed [S_WIDTH-1:0]         ext_im;
   logic signed [S_WIDTH-1:0]         acc_re;
   logic signed [S_WIDTH-1:0]         acc_im;

   // Full-width products, sign-extended, added to the (possibly cleared) accumulators.
   always_comb begin
      prod_re = x * w_re;
      prod_im = x * w_im;
      ext_re  = prod_re;
      ext_im  = prod_im;
      sum_re  = (first ? '0 : acc_re) + ext_re;
      sum_im  = (first ? '0 : acc_im) + ext_im;
   end

   // Accumulators advance only on accepted samples.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         acc_re <= '0;
         acc_im <= '0;
      end else if (en) begin
         acc_re <= sum_re;
         acc_im <= sum_im;
      end
   end

endmodule

// File: rtl/serial_dft_bins.sv
// Multi-bin streaming DFT: NUM_BINS complex MAC lanes over FRAME_LENGTH real
// samples, one-frame result buffer drained one bin per cycle (valid/ready).
// Optional feature: SERIAL_DFT_SAT_EN (saturating narrowing, see dft_pkg).
module serial_dft_bins import dft_pkg::*; #(
   parameter int unsigned W_WIDTH      = DFT_W_WIDTH,
   parameter int unsigned X_WIDTH      = DFT_X_WIDTH,
   parameter int unsigned S_WIDTH      = DFT_S_WIDTH,
   parameter int unsigned O_WIDTH      = DFT_O_WIDTH,
   parameter int unsigned FRAME_LENGTH = 8,
   parameter int unsigned NUM_BINS     = 4,
   parameter int unsigned SHIFT        = 0,
   localparam int unsigned BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
   input  logic                                             clk,
   input  logic                                             arstn,
   input  logic [NUM_BINS-1:0][FRAME_LENGTH-1:0][W_WIDTH-1:0] w_re,
   input  logic [NUM_BINS-1:0][FRAME_LENGTH-1:0][W_WIDTH-1:0] w_im,
   input  logic                                             valid_i,
   input  logic                                             sof_i,
   input  logic [X_WIDTH-1:0]                               x_i,
   output logic                                             out_valid_o,
   input  logic                                             out_ready_i,
   output logic [BW-1:0]                                    bin_o,
   output logic [O_WIDTH-1:0]                               re_o,
   output logic [O_WIDTH-1:0]                               im_o,
   output logic                                             last_o,
   output logic                                             overrun_o
);

   localparam int unsigned NW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
   localparam logic [NW-1:0] LAST_N   = NW'(FRAME_LENGTH - 1);
   localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

   dft_state_t               state;
   logic [BW-1:0]            ptr;
   logic [NW-1:0]            n;
   logic [NW-1:0]            idx;
   logic                     first;
   logic                     done;
   logic                     handshake;
   logic                     can_load;
   logic signed [S_WIDTH-1:0] sum_re [NUM_BINS];
   logic signed [S_WIDTH-1:0] sum_im [NUM_BINS];
   logic [O_WIDTH-1:0]        nar_re [NUM_BINS];
   logic [O_WIDTH-1:0]        nar_im [NUM_BINS];
   logic [O_WIDTH-1:0]        buf_re [NUM_BINS];
   logic [O_WIDTH-1:0]        buf_im [NUM_BINS];

   // A start-of-frame sample forces index 0, which restarts every lane.
   assign idx       = sof_i ? '0 : n;
   assign first     = (idx == '0);
   assign done      = valid_i && (idx == LAST_N);
   assign handshake = (state == DRAIN) && out_ready_i;
   assign can_load  = (state == IDLE) || (handshake && (ptr == LAST_BIN));

   for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
      dft_cmac #(
         .W_WIDTH(W_WIDTH),
         .X_WIDTH(X_WIDTH),
         .S_WIDTH(S_WIDTH)
      ) u_cmac (
         .clk   (clk),
         .arstn (arstn),
         .en    (valid_i),
         .first (first),
         .x     (x_i),
         .w_re  (w_re[k][idx]),
         .w_im  (w_im[k][idx]),
         .sum_re(sum_re[k]),
         .sum_im(sum_im[k])
      );
   end

   // Sample index counter, wrapping at the end of a frame.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) n <= '0;
      else if (valid_i) n <= (idx == LAST_N) ? '0 : idx + 1'b1;
   end

   // Scale and narrow the final sums before they enter the result buffer.
   always_comb begin
      for (int unsigned k = 0; k < NUM_BINS; k++) begin
         nar_re[k] = O_WIDTH'(sat_narrow(64'(sum_re[k] >>> SHIFT), O_WIDTH));
         nar_im[k] = O_WIDTH'(sat_narrow(64'(sum_im[k] >>> SHIFT), O_WIDTH));
      end
   end

   // Output FSM: buffer load, drain pointer and overrun reporting.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state     <= IDLE;
         ptr       <= '0;
         overrun_o <= 1'b0;
         for (int unsigned k = 0; k < NUM_BINS; k++) begin
            buf_re[k] <= '0;
            buf_im[k] <= '0;
         end
      end else begin
         overrun_o <= 1'b0;
         if (done && can_load) begin
            state <= DRAIN;
            ptr   <= '0;
            for (int unsigned k = 0; k < NUM_BINS; k++) begin
               buf_re[k] <= nar_re[k];
               buf_im[k] <= nar_im[k];
            end
         end else begin
            if (done) overrun_o <= 1'b1;
            if (handshake) begin
               if (ptr == LAST_BIN) begin
                  state <= IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
         end
      end
   end

   assign out_valid_o = (state == DRAIN);
   assign last_o      = (state == DRAIN) && (ptr == LAST_BIN);
   assign bin_o       = ptr;
   assign re_o        = buf_re[ptr];
   assign im_o        = buf_im[ptr];

endmodule
